// File: rtl/dmem_resp.sv
// dmem_resp -- byte-addressed data memory with a fixed-latency response.
//
// A request is accepted in IDLE and held for WAIT_CYCLES wait states.
// Then the memory is accessed and ack pulses for one cycle.
// Data is big-endian: the lowest address holds the most significant byte of
// a half or word. The address wraps modulo DEPTH_BYTES. Reset does not clear
// the memory contents.
//
// Parameters
//   WAIT_CYCLES  wait states between acceptance and response (0..15)
//   DEPTH_BYTES  memory capacity in bytes (power of two, >= 4)
//
// Ports
//   clk    in   system clock, rising edge
//   reset  in   asynchronous, active-high reset
//   req    in   request strobe, sampled only in IDLE
//   we     in   1 = store, 0 = load
//   size   in   00 byte, 01 half, 1x word
//   addr   in   byte address
//   wdata  in   store data, right-justified
//   rdata  out  load data, zero-extended; holds between loads
//   ack    out  one-cycle response pulse
//   busy   out  high from acceptance through the ack cycle
//   err    out  misalignment flag, valid with ack
//
// Build option
//   DMEM_MISALIGN_CHK_EN  defined: a misaligned half or word access makes no
//                         memory access, leaves rdata unchanged, and raises
//                         err together with ack.
//                         undefined: the address is forced aligned and err
//                         is always 0.
module dmem_resp #(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH_BYTES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        busy,
    output logic        err
);

    localparam int AW    = $clog2(DEPTH_BYTES);
    localparam int WORDS = DEPTH_BYTES / 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]    state_reg;
    logic [3:0]    cnt_reg;
    logic          we_reg;
    logic [1:0]    size_reg;
    logic [AW-1:0] addr_reg;
    logic [31:0]   wdata_reg;
    logic [31:0]   rdata_reg;

    // Address bits above the array size are ignored (wrap-around).
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:AW];

    // With zero wait states the access happens on the acceptance edge.
    // The live inputs then stand in for the latched fields, which are not
    // loaded yet.
    logic          in_idle;
    logic          cur_we;
    logic [1:0]    cur_size;
    logic [AW-1:0] cur_addr;
    logic [31:0]   cur_wdata;

    assign in_idle   = (state_reg == ST_IDLE);
    assign cur_we    = in_idle ? we              : we_reg;
    assign cur_size  = in_idle ? size            : size_reg;
    assign cur_addr  = in_idle ? addr[AW-1:0]    : addr_reg;
    assign cur_wdata = in_idle ? wdata           : wdata_reg;

    // go_resp marks the edge that enters RESP: the access happens here.
    logic go_resp;
    assign go_resp = (in_idle && req && (WAIT_CYCLES == 0))
                   || ((state_reg == ST_WAIT) && (cnt_reg == 4'd1));

    logic       access_en;
    logic [1:0] ea_lo;

`ifdef DMEM_MISALIGN_CHK_EN
    logic misaligned;
    assign misaligned = ((cur_size == 2'b01) && cur_addr[0])
                      || (cur_size[1] && (cur_addr[1:0] != 2'b00));
    assign ea_lo      = cur_addr[1:0];
    // reset gating keeps a same-edge W=0 request from writing during reset
    assign access_en  = go_resp && !misaligned && !reset;
    assign err        = (state_reg == ST_RESP) && misaligned;
`else
    always_comb begin
        case (cur_size)
            2'b00:   ea_lo = cur_addr[1:0];
            2'b01:   ea_lo = {cur_addr[1], 1'b0};
            default: ea_lo = 2'b00;
        endcase
    end
    assign access_en = go_resp && !reset;
    assign err       = 1'b0;
`endif

    logic [AW-3:0]   widx;
    logic [3:0][7:0] lane_q;
    assign widx = cur_addr[AW-1:2];

    // One byte-wide bank per lane. Lane k holds the byte at word address
    // offset k, so a word reads as {lane0, lane1, lane2, lane3}.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic [7:0] bank [WORDS];
            logic       sel;
            logic [7:0] wd;

            always_comb begin
                case (cur_size)
                    2'b00: begin
                        sel = (ea_lo == LANE);
                        wd  = cur_wdata[7:0];
                    end
                    2'b01: begin
                        sel = (ea_lo[1] == LANE[1]);
                        wd  = LANE[0] ? cur_wdata[7:0] : cur_wdata[15:8];
                    end
                    default: begin
                        sel = 1'b1;
                        wd  = cur_wdata[31-8*gi -: 8];
                    end
                endcase
            end

            // The bank has no reset, so its contents survive reset.
            always_ff @(posedge clk) begin
                if (access_en && cur_we && sel) begin
                    bank[widx] <= wd;
                end
            end

            assign lane_q[gi] = bank[widx];
        end
    endgenerate

    logic [31:0] rdata_next;
    always_comb begin
        case (cur_size)
            2'b00:   rdata_next = {24'h0, lane_q[ea_lo]};
            2'b01:   rdata_next = {16'h0, lane_q[{ea_lo[1], 1'b0}],
                                          lane_q[{ea_lo[1], 1'b1}]};
            default: rdata_next = {lane_q[0], lane_q[1], lane_q[2], lane_q[3]};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_reg <= 32'h0;
        end else if (access_en && !cur_we) begin
            rdata_reg <= rdata_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
            we_reg    <= 1'b0;
            size_reg  <= 2'b00;
            addr_reg  <= '0;
            wdata_reg <= 32'h0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req) begin
                        we_reg    <= we;
                        size_reg  <= size;
                        addr_reg  <= addr[AW-1:0];
                        wdata_reg <= wdata;
                        cnt_reg   <= 4'(WAIT_CYCLES);
                        state_reg <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt_reg <= cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1) begin
                        state_reg <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign rdata = rdata_reg;
    assign ack   = (state_reg == ST_RESP);
    assign busy  = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_dmem_resp.sv
// Testbench for dmem_resp.
//
// A transaction-level model tracks acceptance, response timing, a byte-array
// memory and the expected rdata. One negedge process compares every output
// with the model on each cycle. Directed transactions also check hand-computed
// literal values. A randomized phase follows, with occasional asynchronous
// resets.
module tb_dmem_resp;

    localparam int W  = 2;
    localparam int DB = 4096;
`ifdef DMEM_MISALIGN_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        ack;
    logic        busy;
    logic        err;

    dmem_resp #(.WAIT_CYCLES(W), .DEPTH_BYTES(DB)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .we    (we),
        .size  (size),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .ack   (ack),
        .busy  (busy),
        .err   (err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  mm [DB];
    int          cyc = 0;
    int          acc = -1000;
    bit          pend = 1'b0;
    bit          bb;
    bit          m_we;
    logic [1:0]  m_size;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata = 32'h0;
    bit          e_ack = 1'b0;
    bit          e_busy = 1'b0;
    bit          e_err = 1'b0;

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : ((s == 2'd1) ? 2 : 4);
    endfunction

    function automatic bit misal(input logic [1:0] s, input logic [31:0] a);
        return ((s == 2'd1) && (a % 2 != 0)) || ((s >= 2'd2) && (a % 4 != 0));
    endfunction

    task automatic apply();
        int base;
        int n;
        logic [31:0] v;
        n    = nbytes(m_size);
        base = int'(m_addr % DB);
        if (CHK && misal(m_size, m_addr)) return;
        base = base - (base % n);
        if (m_we) begin
            for (int i = 0; i < n; i++)
                mm[base + i] = 8'(m_wdata >> (8 * (n - 1 - i)));
        end else begin
            v = 32'h0;
            for (int i = 0; i < n; i++)
                v = (v << 8) | {24'h0, mm[base + i]};
            m_rdata = v;
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pend    = 1'b0;
            acc     = -1000;
            m_rdata = 32'h0;
            e_ack   = 1'b0;
            e_busy  = 1'b0;
            e_err   = 1'b0;
        end else begin
            cyc++;
            bb = pend && (cyc - 1 <= acc + W);
            if (pend && cyc == acc + W) apply();
            if (pend && cyc > acc + W) pend = 1'b0;
            if (!bb && req) begin
                acc = cyc; pend = 1'b1;
                m_we = we; m_size = size; m_addr = addr; m_wdata = wdata;
                $display("txn cyc=%0d we=%0b size=%0d addr=%h wdata=%h", cyc, we, size, addr, wdata);
                if (W == 0) apply();
            end
            e_busy = pend && (cyc <= acc + W);
            e_ack  = pend && (cyc == acc + W);
            e_err  = e_ack && CHK && misal(m_size, m_addr);
        end
    end

    // ---------------- compare process ----------------
    bit chk_en  = 1'b0;
    int ack_cnt = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("ack",   {31'h0, ack},  {31'h0, e_ack});
            check("busy",  {31'h0, busy}, {31'h0, e_busy});
            check("err",   {31'h0, err},  {31'h0, e_err});
            check("rdata", rdata, m_rdata);
            if (ack) ack_cnt++;
        end
    end

    // ---------------- directed helpers ----------------
    task automatic xact(input bit w, input logic [1:0] s, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output bit e);
        bit got;
        got = 1'b0;
        e   = 1'b0;
        lat = 0;
        @(negedge clk); #1;
        req = 1'b1; we = w; size = s; addr = a; wdata = d;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat = i + 1;
            got = ack;
            e   = err;
            #1 req = 1'b0;
            if (got) break;
        end
        check("ack_seen", {31'h0, got}, 32'h1);
    endtask

    int lat;
    bit e;
    int a0;

    initial begin
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_rdata", rdata, 32'h0);
        check("rst_ack",   {31'h0, ack},  32'h0);
        check("rst_busy",  {31'h0, busy}, 32'h0);
        check("rst_err",   {31'h0, err},  32'h0);
        #2 reset = 1'b0;
        chk_en = 1'b1;

        // initialise the low 64 bytes so every later load is defined
        for (int i = 0; i < 16; i++) xact(1'b1, 2'd2, 32'(i * 4), $urandom, lat, e);

        xact(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, lat, e);
        check("lat_store", 32'(lat), 32'(W + 1));
        xact(1'b0, 2'd2, 32'h10, 32'h0, lat, e);
        check("lat_load", 32'(lat), 32'(W + 1));
        check("ld_word", rdata, 32'hDEADBEEF);
        xact(1'b0, 2'd0, 32'h11, 32'h0, lat, e);
        check("ld_byte", rdata, 32'h000000AD);
        xact(1'b0, 2'd1, 32'h12, 32'h0, lat, e);
        check("ld_half", rdata, 32'h0000BEEF);
        xact(1'b1, 2'd0, 32'h13, 32'h00000077, lat, e);
        check("st_keeps_rdata", rdata, 32'h0000BEEF);
        xact(1'b0, 2'd2, 32'h10, 32'h0, lat, e);
        check("ld_after_stb", rdata, 32'hDEADBE77);

        xact(1'b1, 2'd2, 32'h1010, 32'h12345678, lat, e);
        xact(1'b0, 2'd2, 32'h10, 32'h0, lat, e);
        check("wrap", rdata, 32'h12345678);

        // second request while busy must be dropped
        xact(1'b1, 2'd2, 32'h34, 32'h55667788, lat, e);
        a0 = ack_cnt;
        @(negedge clk); #1;
        req = 1'b1; we = 1'b1; size = 2'd2; addr = 32'h30; wdata = 32'h0A0B0C0D;
        @(negedge clk); #1;
        addr = 32'h34; wdata = 32'hFFFFFFFF;
        @(negedge clk); #1;
        req = 1'b0;
        repeat (6) @(negedge clk);
        #1 check("busy_ack_count", 32'(ack_cnt - a0), 32'h1);
        xact(1'b0, 2'd2, 32'h30, 32'h0, lat, e);
        check("busy_first", rdata, 32'h0A0B0C0D);
        xact(1'b0, 2'd2, 32'h34, 32'h0, lat, e);
        check("busy_second_dropped", rdata, 32'h55667788);

        // reset in WAIT aborts a store
        xact(1'b1, 2'd2, 32'h20, 32'h11223344, lat, e);
        @(negedge clk); #1;
        req = 1'b1; we = 1'b1; size = 2'd2; addr = 32'h20; wdata = 32'hCAFEF00D;
        @(negedge clk); #1;
        req = 1'b0;
        a0 = ack_cnt;
        #1 reset = 1'b1;
        #1;
        check("abort_busy",  {31'h0, busy}, 32'h0);
        check("abort_ack",   {31'h0, ack},  32'h0);
        check("abort_rdata", rdata, 32'h0);
        @(negedge clk); #2 reset = 1'b0;
        xact(1'b0, 2'd2, 32'h20, 32'h0, lat, e);
        check("abort_mem", rdata, 32'h11223344);
        check("abort_no_ack", 32'(ack_cnt - a0), 32'h1);

        // misaligned word load
        xact(1'b0, 2'd2, 32'h22, 32'h0, lat, e);
        check("misalign_rdata", rdata, 32'h11223344);
        check("misalign_err", {31'h0, e}, {31'h0, CHK});

        // randomized phase
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); #1;
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                req   = 1'b0;
                @(negedge clk); #1;
                reset = 1'b0;
            end else begin
                req   = ($urandom_range(0, 3) == 0);
                we    = 1'($urandom);
                size  = 2'($urandom);
                addr  = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63));
                wdata = $urandom;
            end
        end
        @(negedge clk); #1 req = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
